// File: rtl/fxp_div_seq_if.sv
// Operand load, start and result bundle for the sequential fixed-point divider.
// Master drives operands and start; slave returns busy/done and the results.
interface fxp_div_seq_if #(
  parameter int W = 10
);
  logic         ld_a;
  logic         ld_b;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] rem;
  logic         ov;
  logic         dbz;

  modport master (
    output ld_a, ld_b, A, B, start,
    input  busy, done, q, rem, ov, dbz
  );

  modport slave (
    input  ld_a, ld_b, A, B, start,
    output busy, done, q, rem, ov, dbz
  );
endinterface

// File: rtl/fxp_div_seq.sv
// Restoring divider: q = floor(A*2^F / B) over W+F iterations.
// FXDIV_DBZ_EN: a zero divisor completes one edge after start.
module fxp_div_seq #(
  parameter int W = 10,
  parameter int F = 4
) (
  input  logic          clk,
  input  logic          rst,
  fxp_div_seq_if.slave  io
);

  localparam int N  = W + F;
  localparam int CW = $clog2(N + 1);

`ifdef FXDIV_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t           st_q, st_d;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  r_q;
  logic [N-1:0]  d_q, qw_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [W-1:0]  q_q, rem_q;
  logic          ov_q, dbz_q;

  logic [W:0]    t;
  logic          ge;
  logic [W-1:0]  r_nx;
  logic [N-1:0]  qw_nx;
  logic          ov_nx;
  logic          go;
  logic          fin;
  logic          zfin;

  // R never exceeds B-1, so W bits hold it; T keeps the extra bit for the compare.
  always_comb begin
    t     = {r_q, d_q[N-1]};
    ge    = (t >= {1'b0, b_q});
    r_nx  = ge ? W'(t - {1'b0, b_q}) : t[W-1:0];
    qw_nx = N'({qw_q, ge});
    ov_nx = |(qw_nx >> W);
  end

  always_comb begin
    st_d = st_q;
    go   = 1'b0;
    fin  = 1'b0;
    zfin = 1'b0;
    unique case (st_q)
      IDLE, DONE: begin
        if (io.start) begin
          st_d = RUN;
          go   = 1'b1;
        end else begin
          st_d = IDLE;
        end
      end
      RUN: begin
        if (DBZ && b_q == '0) begin
          st_d = DONE;
          zfin = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          st_d = DONE;
          fin  = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      qw_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= '0;
      rem_q  <= '0;
      ov_q   <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      busy_q <= (st_d == RUN);
      done_q <= (st_d == DONE);
      if (st_q != RUN) begin
        if (io.ld_a) a_q <= io.A;
        if (io.ld_b) b_q <= io.B;
      end
      if (go) begin
        r_q   <= '0;
        d_q   <= N'(a_q) << F;
        qw_q  <= '0;
        cnt_q <= CW'(N);
      end else if (st_q == RUN) begin
        r_q   <= r_nx;
        d_q   <= {d_q[N-2:0], 1'b0};
        qw_q  <= qw_nx;
        cnt_q <= cnt_q - CW'(1);
      end
      // A zero divisor reports the dividend as the remainder.
      if (fin) begin
        q_q   <= qw_nx[W-1:0];
        rem_q <= (b_q == '0) ? a_q : r_nx;
        ov_q  <= ov_nx;
        dbz_q <= 1'b0;
      end else if (zfin) begin
        q_q   <= '1;
        rem_q <= a_q;
        ov_q  <= 1'b1;
        dbz_q <= 1'b1;
      end
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.q    = q_q;
  assign io.rem  = rem_q;
  assign io.ov   = ov_q;
  assign io.dbz  = dbz_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed-vector bench for fxp_div_seq at W=10, F=4.
// Honours FXDIV_DBZ_EN for zero-divisor latency and flag.
module tb_fxp_div_seq;

  localparam int W = 10;
  localparam int F = 4;

`ifdef FXDIV_DBZ_EN
  localparam int  ZLAT = 1;
  localparam logic ZDBZ = 1'b1;
`else
  localparam int  ZLAT = W + F;
  localparam logic ZDBZ = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fxp_div_seq_if #(.W(W)) io ();

  fxp_div_seq #(.W(W), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    io.ld_a = 1'b1;
    io.ld_b = 1'b1;
    io.A    = a;
    io.B    = b;
    tick();
    io.ld_a = 1'b0;
    io.ld_b = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat_exp);
    int lat;
    lat = 0;
    while (!io.done && lat < 40) begin
      if (io.busy && io.done) chk({nm, " busy&done"}, 1, 0);
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, lat_exp);
    chk({nm, " busy@done"}, int'(io.busy), 0);
  endtask

  task automatic go_start(input string nm);
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    chk({nm, " busy@start"}, int'(io.busy), 1);
  endtask

  task automatic chk_res(input string nm, input vec_t v, input logic dz);
    chk({nm, " q"}, int'(io.q), int'(v.q));
    chk({nm, " rem"}, int'(io.rem), int'(v.rem));
    chk({nm, " ov"}, int'(io.ov), int'(v.ov));
    chk({nm, " dbz"}, int'(io.dbz), int'(dz));
  endtask

  vec_t vt[10];

  initial begin
    vec_t v;
    io.ld_a  = 1'b0;
    io.ld_b  = 1'b0;
    io.A     = '0;
    io.B     = '0;
    io.start = 1'b0;

    vt[0] = '{a: 10,   b: 4,    q: 40,   rem: 0,  ov: 0};
    vt[1] = '{a: 1,    b: 3,    q: 5,    rem: 1,  ov: 0};
    vt[2] = '{a: 0,    b: 7,    q: 0,    rem: 0,  ov: 0};
    vt[3] = '{a: 1023, b: 1,    q: 1008, rem: 0,  ov: 1};
    vt[4] = '{a: 5,    b: 0,    q: 1023, rem: 5,  ov: 1};
    vt[5] = '{a: 1023, b: 1023, q: 16,   rem: 0,  ov: 0};
    vt[6] = '{a: 100,  b: 7,    q: 228,  rem: 4,  ov: 0};
    vt[7] = '{a: 1023, b: 1022, q: 16,   rem: 16, ov: 0};
    vt[8] = '{a: 64,   b: 1,    q: 0,    rem: 0,  ov: 1};
    vt[9] = '{a: 500,  b: 3,    q: 618,  rem: 2,  ov: 1};

    #12;
    chk("rst busy", int'(io.busy), 0);
    chk("rst done", int'(io.done), 0);
    chk("rst q", int'(io.q), 0);
    chk("rst rem", int'(io.rem), 0);
    chk("rst ov", int'(io.ov), 0);
    chk("rst dbz", int'(io.dbz), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      string nm;
      logic  zd;
      nm = $sformatf("vec%0d", i);
      zd = (vt[i].b == 0) ? ZDBZ : 1'b0;
      load(vt[i].a, vt[i].b);
      go_start(nm);
      wait_done(nm, (vt[i].b == 0) ? ZLAT : W + F);
      chk_res(nm, vt[i], zd);
      tick();
      chk({nm, " done pulse"}, int'(io.done), 0);
      chk({nm, " hold q"}, int'(io.q), int'(vt[i].q));
    end

    // Start and ld_a mid-run must be ignored.
    load(10, 4);
    go_start("midrun");
    repeat (5) tick();
    io.ld_a  = 1'b1;
    io.A     = 999;
    io.start = 1'b1;
    tick();
    io.ld_a  = 1'b0;
    io.start = 1'b0;
    chk("midrun busy", int'(io.busy), 1);
    wait_done("midrun", W + F - 6);
    chk_res("midrun", vt[0], 1'b0);

    // Back-to-back start in DONE; same-edge ld_a must not affect it.
    tick();
    load(1, 3);
    go_start("b2b1");
    wait_done("b2b1", W + F);
    io.start = 1'b1;
    io.ld_a  = 1'b1;
    io.A     = 10;
    tick();
    io.start = 1'b0;
    io.ld_a  = 1'b0;
    chk("b2b done", int'(io.done), 0);
    chk("b2b busy", int'(io.busy), 1);
    wait_done("b2b2", W + F);
    chk_res("b2b2", vt[1], 1'b0);
    tick();
    io.B = 4;
    io.ld_b = 1'b1;
    tick();
    io.ld_b = 1'b0;
    go_start("b2b3");
    wait_done("b2b3", W + F);
    chk_res("b2b3", vt[0], 1'b0);

    // Asynchronous reset mid-run.
    tick();
    load(1023, 1);
    go_start("rstrun");
    repeat (6) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mrst busy", int'(io.busy), 0);
    chk("mrst done", int'(io.done), 0);
    chk("mrst q", int'(io.q), 0);
    chk("mrst rem", int'(io.rem), 0);
    chk("mrst ov", int'(io.ov), 0);
    chk("mrst dbz", int'(io.dbz), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    load(10, 4);
    go_start("post");
    wait_done("post", W + F);
    v = vt[0];
    chk_res("post", v, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
